alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits.
REQ-002 SHALL have port `i_clk  in  1`: sole clock, all state updates on rising edge.
REQ-003 SHALL have port `i_rst  in  1`: reset, asynchronous and active-high.
REQ-004 SHALL have port `i_valid  in  1`: upstream instruction valid.
REQ-005 SHALL have port `o_ready  out  1`: upstream may transfer; transfer occurs when i_valid & o_ready at a clock edge.
REQ-006 SHALL have port `i_instr  in  32`: RV32I instruction word.
REQ-007 SHALL have ports `i_rs1_data` and `i_rs2_data`, both `in  32`: register operands.
REQ-008 SHALL have port `o_valid  out  1`: issue entry valid toward the ALU.
REQ-009 SHALL have port `i_ready  in  1`: downstream accepts; pop occurs when o_valid & i_ready at a clock edge.
REQ-010 SHALL have port `o_ctrl  out  3`: ALU op code; 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sra, 110 srl, 111 sll.
REQ-011 SHALL have ports `o_op1` and `o_op2`, both `out  32`: ALU operands.
REQ-012 SHALL have port `o_cmp  out  2`: 00 none, 01 slt (take sign flag), 10 sltu (take unsigned-sign flag).
REQ-013 SHALL have ports `o_br_en  out  1` (branch) and `o_br_funct3  out  3` (branch condition, copied from instr[14:12]).
REQ-014 SHALL have port `o_illegal  out  1`: entry holds an undecodable instruction.

Function
REQ-015 SHALL decode on transfer and store decoded fields in a 2-entry in-order buffer; the outputs SHALL always present the head entry.
REQ-016 Latency SHALL be 1 cycle: an instruction accepted into an empty buffer appears with o_valid=1 in the next cycle.
REQ-017 o_ready SHALL equal "buffer not full", driven from registered state only; it SHALL NOT depend combinationally on i_ready.
REQ-018 Simultaneous push and pop with 1 entry SHALL keep the count at 1 and present the new entry; push and pop on empty is impossible (head not valid).
REQ-019 When full, no push SHALL occur, whatever i_valid is; a pop SHALL raise o_ready the next cycle.
REQ-020 Head outputs SHALL be held stable while o_valid=1 and i_ready=0.
REQ-021 OP (opcode 0110011), funct7=0000000, SHALL decode funct3 as:
- 000 add
- 001 sll
- 010 sub with cmp=01
- 011 sub with cmp=10
- 100 xor
- 101 srl
- 110 or
- 111 and
REQ-022 OP with funct7=0100000 SHALL decode funct3 000 as sub and 101 as sra; any other OP funct7/funct3 pairing SHALL be illegal.
REQ-023 For OP, op1=rs1 and op2=rs2, except shifts where op2={27'b0, rs2[4:0]}.
REQ-024 OP-IMM (0010011) SHALL use funct3 mapping as REQ-021, with these differences:
- op2 = sign-extended instr[31:20], no sub.
- Shifts: op2={27'b0, instr[24:20]}.
- slli/srli require instr[31:25]=0000000; srai requires 0100000; otherwise illegal.
REQ-025 BRANCH (1100011) SHALL decode with:
- ctrl=001, op1=rs1, op2=rs2, br_en=1, cmp=00.
- funct3 010 or 011 SHALL be illegal.
REQ-026 Any other opcode SHALL be illegal.
REQ-027 Illegal entries SHALL still be buffered and issued in order with o_illegal=1, ctrl=000, op1=op2=0, cmp=00, br_en=0.
REQ-028 br_en SHALL be 0 for non-branch entries.

Reset
REQ-029 While i_rst=1, asynchronously:
- buffer empties.
- o_valid=0.
- o_ready=1.
- o_ctrl=000, o_op1=o_op2=0, o_cmp=00, o_br_en=0, o_br_funct3=000, o_illegal=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries, including any transfer at that edge.
REQ-031 The first transfer SHALL be possible at the first rising edge after i_rst deasserts.

Verification
REQ-032 The bench SHALL cover add: instr 0x002081B3 with rs1=5, rs2=7, i_ready=1 -> next cycle o_valid=1, ctrl=000, op1=5, op2=7, cmp=00, illegal=0.
REQ-033 The bench SHALL cover srai: instr 0x4030D093 (shamt 3), rs1=0x80000000 -> ctrl=101, op2=3; sll reg with rs2=0xFFFFFF21 -> op2=1.
REQ-034 The bench SHALL cover sltu and branch:
- sltu -> ctrl=001, cmp=10.
- bltu (funct3 110) -> ctrl=001, br_en=1, br_funct3=110.
- funct3 010 on BRANCH -> illegal=1, operands 0.
REQ-035 The bench SHALL cover backpressure: i_ready=0, push A then B -> o_ready=0 after the 2nd push, and a 3rd valid is not accepted. i_ready=1 -> A, then B, in order; o_ready=1 one cycle after the first pop.
REQ-036 The bench SHALL cover simultaneous events: count=1 with push and pop in the same edge -> count stays 1, new entry at head, no loss or duplication.
REQ-037 The bench SHALL cover reset: assert i_rst mid-stream with 2 entries -> immediately o_valid=0 and o_ready=1; after release, the buffer is empty and the next push issues with 1-cycle latency.

Source files
------------

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I ALU issue stage: decodes on transfer into a 2-entry in-order buffer.
module alu_issue (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [2:0]  o_ctrl,
   output logic [31:0] o_op1,
   output logic [31:0] o_op2,
   output logic [1:0]  o_cmp,
   output logic        o_br_en,
   output logic [2:0]  o_br_funct3,
   output logic        o_illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRA = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_SLL = 3'b111;

   typedef struct packed {
      logic [2:0]  ctrl;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [1:0]  cmp;
      logic        br_en;
      logic [2:0]  br_funct3;
      logic        illegal;
   } entry_t;

   function automatic logic [2:0] alu_of(input logic [2:0] f3);
      case (f3)
         3'b000:  alu_of = ALU_ADD;
         3'b001:  alu_of = ALU_SLL;
         3'b010:  alu_of = ALU_SUB;
         3'b011:  alu_of = ALU_SUB;
         3'b100:  alu_of = ALU_XOR;
         3'b101:  alu_of = ALU_SRL;
         3'b110:  alu_of = ALU_OR;
         default: alu_of = ALU_AND;
      endcase
   endfunction

   function automatic logic [1:0] cmp_of(input logic [2:0] f3);
      case (f3)
         3'b010:  cmp_of = 2'b01;
         3'b011:  cmp_of = 2'b10;
         default: cmp_of = 2'b00;
      endcase
   endfunction

   logic [1:0] count_q, count_d;
   entry_t     head_q, head_d;
   entry_t     tail_q, tail_d;
   entry_t     dec;
   logic       ill;
   logic       push, pop;
   logic [6:0] opcode, f7;
   logic [2:0] f3;
   logic       is_shift;

   assign opcode   = i_instr[6:0];
   assign f3       = i_instr[14:12];
   assign f7       = i_instr[31:25];
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

   always_comb begin
      dec = '0;
      ill = 1'b0;
      dec.br_funct3 = f3;
      case (opcode)
         OPC_OP: begin
            dec.op1 = i_rs1_data;
            dec.op2 = is_shift ? {27'b0, i_rs2_data[4:0]} : i_rs2_data;
            if (f7 == F7_ZERO) begin
               dec.ctrl = alu_of(f3);
               dec.cmp  = cmp_of(f3);
            end else if (f7 == F7_ALT && f3 == 3'b000) begin
               dec.ctrl = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == 3'b101) begin
               dec.ctrl = ALU_SRA;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec.op1  = i_rs1_data;
            dec.op2  = is_shift ? {27'b0, i_instr[24:20]} : {{20{i_instr[31]}}, i_instr[31:20]};
            dec.ctrl = alu_of(f3);
            dec.cmp  = cmp_of(f3);
            // Shift immediates reuse the funct7 field to pick logical vs arithmetic
            if (f3 == 3'b001 && f7 != F7_ZERO) ill = 1'b1;
            if (f3 == 3'b101) begin
               if (f7 == F7_ALT)       dec.ctrl = ALU_SRA;
               else if (f7 != F7_ZERO) ill = 1'b1;
            end
         end
         OPC_BRANCH: begin
            dec.ctrl  = ALU_SUB;
            dec.op1   = i_rs1_data;
            dec.op2   = i_rs2_data;
            dec.br_en = 1'b1;
            if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         dec = '0;
         dec.illegal   = 1'b1;
         dec.br_funct3 = f3;
      end
   end

   assign o_ready = (count_q != 2'd2);
   assign o_valid = (count_q != 2'd0);
   assign push    = i_valid & o_ready;
   assign pop     = o_valid & i_ready;

   always_comb begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      head_d  = head_q;
      tail_d  = tail_q;
      if (pop) head_d = tail_q;
      // New entry lands in the head slot whenever the buffer is empty after this pop
      if (push) begin
         if (count_q == 2'd0 || (count_q == 2'd1 && pop)) head_d = dec;
         else                                             tail_d = dec;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign o_ctrl      = head_q.ctrl;
   assign o_op1       = head_q.op1;
   assign o_op2       = head_q.op2;
   assign o_cmp       = head_q.cmp;
   assign o_br_en     = head_q.br_en;
   assign o_br_funct3 = head_q.br_funct3;
   assign o_illegal   = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue.
module tb_alu_issue;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_instr;
   logic [31:0] i_rs1_data;
   logic [31:0] i_rs2_data;
   logic        o_valid;
   logic        i_ready;
   logic [2:0]  o_ctrl;
   logic [31:0] o_op1;
   logic [31:0] o_op2;
   logic [1:0]  o_cmp;
   logic        o_br_en;
   logic [2:0]  o_br_funct3;
   logic        o_illegal;

   int checks = 0;
   int failures = 0;

   alu_issue dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_instr(i_instr), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
      .o_valid(o_valid), .i_ready(i_ready), .o_ctrl(o_ctrl), .o_op1(o_op1),
      .o_op2(o_op2), .o_cmp(o_cmp), .o_br_en(o_br_en),
      .o_br_funct3(o_br_funct3), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      i_valid = v;
      i_instr = ins;
      i_rs1_data = a;
      i_rs2_data = b;
   endtask

   initial begin
      i_rst = 1'b1;
      i_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      tick();
      tick();
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_ctrl", o_ctrl, 0);
      chk("rst_op1", o_op1, 0);
      chk("rst_op2", o_op2, 0);
      chk("rst_illegal", o_illegal, 0);
      chk("rst_brf3", o_br_funct3, 0);

      // add, first edge after release
      i_rst = 1'b0;
      i_ready = 1'b1;
      drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
      tick();
      chk("add_valid", o_valid, 1);
      chk("add_ctrl", o_ctrl, 3'b000);
      chk("add_op1", o_op1, 5);
      chk("add_op2", o_op2, 7);
      chk("add_cmp", o_cmp, 0);
      chk("add_illegal", o_illegal, 0);

      drive(1'b1, 32'h4030D093, 32'h80000000, 32'h0);
      tick();
      chk("srai_ctrl", o_ctrl, 3'b101);
      chk("srai_op1", o_op1, 32'h80000000);
      chk("srai_op2", o_op2, 3);
      chk("srai_valid", o_valid, 1);

      drive(1'b1, 32'h002091B3, 32'h1234, 32'hFFFFFF21);
      tick();
      chk("sll_ctrl", o_ctrl, 3'b111);
      chk("sll_op2", o_op2, 1);

      drive(1'b1, 32'h0020B1B3, 32'd3, 32'd9);
      tick();
      chk("sltu_ctrl", o_ctrl, 3'b001);
      chk("sltu_cmp", o_cmp, 2'b10);
      chk("sltu_op2", o_op2, 9);

      drive(1'b1, 32'h0020E063, 32'd10, 32'd20);
      tick();
      chk("bltu_ctrl", o_ctrl, 3'b001);
      chk("bltu_bren", o_br_en, 1);
      chk("bltu_f3", o_br_funct3, 3'b110);
      chk("bltu_cmp", o_cmp, 0);
      chk("bltu_op1", o_op1, 10);

      drive(1'b1, 32'h0020A063, 32'd10, 32'd20);
      tick();
      chk("bill_illegal", o_illegal, 1);
      chk("bill_op1", o_op1, 0);
      chk("bill_op2", o_op2, 0);
      chk("bill_bren", o_br_en, 0);
      chk("bill_ctrl", o_ctrl, 0);

      drive(1'b1, 32'h402091B3, 32'd1, 32'd2);
      tick();
      chk("opf7_illegal", o_illegal, 1);

      drive(1'b1, 32'h4000C1B3, 32'd1, 32'd2);
      tick();
      chk("xorx_illegal", o_illegal, 1);

      drive(1'b1, 32'hFFF08113, 32'd4, 32'd0);
      tick();
      chk("addi_illegal", o_illegal, 0);
      chk("addi_op2", o_op2, 32'hFFFFFFFF);
      chk("addi_bren", o_br_en, 0);

      drive(1'b0, 32'h0, 32'h0, 32'h0);
      tick();
      chk("drain_valid", o_valid, 0);
      chk("drain_ready", o_ready, 1);

      // backpressure
      i_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h11, 32'h22);
      tick();
      chk("bp_a_ready", o_ready, 1);
      chk("bp_a_op1", o_op1, 32'h11);
      drive(1'b1, 32'h0020C1B3, 32'h33, 32'h44);
      tick();
      chk("bp_full_ready", o_ready, 0);
      chk("bp_hold_op1", o_op1, 32'h11);
      drive(1'b1, 32'h0020E1B3, 32'h55, 32'h66);
      tick();
      chk("bp_c_ready", o_ready, 0);
      chk("bp_c_hold_ctrl", o_ctrl, 3'b000);
      chk("bp_c_hold_op1", o_op1, 32'h11);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      i_ready = 1'b1;
      tick();
      chk("bp_b_ctrl", o_ctrl, 3'b100);
      chk("bp_b_op1", o_op1, 32'h33);
      chk("bp_b_ready", o_ready, 1);
      tick();
      chk("bp_empty_valid", o_valid, 0);

      // simultaneous push/pop with one entry
      i_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h66, 32'h1);
      tick();
      chk("sim_d_op1", o_op1, 32'h66);
      i_ready = 1'b1;
      drive(1'b1, 32'h402081B3, 32'h77, 32'h8);
      tick();
      chk("sim_e_valid", o_valid, 1);
      chk("sim_e_ctrl", o_ctrl, 3'b001);
      chk("sim_e_op1", o_op1, 32'h77);
      chk("sim_e_ready", o_ready, 1);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      tick();
      chk("sim_empty_valid", o_valid, 0);

      // reset mid-stream with two entries
      i_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h1, 32'h2);
      tick();
      drive(1'b1, 32'h002081B3, 32'h3, 32'h4);
      tick();
      chk("mid_full", o_ready, 0);
      i_rst = 1'b1;
      #1;
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_ready", o_ready, 1);
      chk("mid_rst_op1", o_op1, 0);
      tick();
      i_rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      tick();
      chk("post_rst_empty", o_valid, 0);
      i_ready = 1'b1;
      drive(1'b1, 32'h002081B3, 32'd9, 32'd3);
      tick();
      chk("post_rst_valid", o_valid, 1);
      chk("post_rst_op1", o_op1, 9);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      tick();
      chk("post_rst_drain", o_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
